cmd_line_ctrl: RTL and testbench
================================

CMD_LINE_CTRL -- requirements
Module: cmd_line_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_BITS, default 64, response-start timeout in SD bit times (Ncr limit).
REQ-002 SHALL have parameter NRC_BITS, default 8, idle bit times enforced after a completed command before cmd_busy falls.
REQ-003 SHALL have parameter LONG_RESP_EN, default 1, enabling 136-bit (R2) reception; when 0, resp_type 11 is treated as 01.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 CLK_host  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 sd_bit_en  input  1  one-cycle strobe marking each SD bit time; all line sampling and driving occur only on strobe cycles.
REQ-008 new_cmd  input  1  one-cycle command request.
REQ-009 cmd_abort  input  1  one-cycle abort request.
REQ-010 cmd_index  input  6  command index.
REQ-011 cmd_arg  input  32  command argument.
REQ-012 resp_type  input  2  00 none, 01 48-bit with CRC, 10 48-bit no CRC/index check (R3), 11 136-bit.
REQ-013 cmd_from_sd  input  1  CMD line input.
REQ-014 cmd_to_sd  output  1  CMD line data; forced to 1 when cmd_to_sd_oe is 0.
REQ-015 cmd_to_sd_oe  output  1  CMD line drive enable.
REQ-016 cmd_busy  output  1  high from acceptance until return to IDLE.
REQ-017 cmd_complete  output  1  one-cycle completion pulse.
REQ-018 resp_index  output  6  received index field (48-bit responses).
REQ-019 response_status  output  128  response payload.
REQ-020 error_flags  output  4  {timeout, crc, end_bit, index}; valid with cmd_complete, held until next acceptance.

Function
REQ-021 new_cmd SHALL be accepted only in IDLE; index, arg, resp_type latched; cmd_busy high the next cycle; new_cmd while busy ignored.
REQ-022 FSM states SHALL be IDLE, TX, WAIT_RESP, RX, CHECK, GAP.
REQ-023 TX SHALL drive 48 bits MSB first, one per strobe: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1; cmd_to_sd_oe high exactly for these 48 strobes.
REQ-024 CRC7 SHALL use polynomial x^7+x^3+1, zero seed, over the first 40 bits.
REQ-025 After TX: resp_type 00 goes to GAP; others go to WAIT_RESP.
REQ-026 WAIT_RESP SHALL sample cmd_from_sd each strobe; first 0 enters RX; TIMEOUT_BITS strobes without a 0 sets timeout and goes to CHECK.
REQ-027 RX SHALL shift 47 further bits (types 01/10) or 135 (type 11), then enter CHECK.
REQ-028 48-bit: resp_index = bits 45:40, response_status[31:0] = bits 39:8, [127:32] = 0; 136-bit: response_status = bits 127:0 (bits after the 8-bit header).
REQ-029 CHECK (one cycle): end_bit set if last bit is 0; for type 01 crc set on CRC7 mismatch over bits 47:8 and index set if resp_index differs from latched index; type 10/11 set only end_bit.
REQ-030 CHECK SHALL pulse cmd_complete and enter GAP; GAP counts NRC_BITS strobes then enters IDLE, dropping cmd_busy.
REQ-031 For resp_type 00, cmd_complete SHALL pulse on the cycle after the 48th TX strobe.
REQ-032 cmd_abort in any non-IDLE state SHALL force IDLE next cycle: oe 0, busy 0, no cmd_complete; abort together with new_cmd in IDLE: new_cmd wins.
REQ-033 Strobes SHALL be the only advance condition; stalled sd_bit_en freezes all counters.

Reset
REQ-034 On reset low: state IDLE, cmd_to_sd 1, cmd_to_sd_oe 0, cmd_busy 0, cmd_complete 0, error_flags 0, resp_index 0, response_status 0, counters 0; reset mid-frame abandons the frame immediately.

Structure
REQ-035 Shared package cmd_pkg SHALL hold the state encoding, resp_type codes, CRC7 polynomial constant and frame lengths (48, 136).
REQ-036 Serial CRC7 SHALL be one sub-module, cmd_crc7 (clear, enable, bit in, 7-bit CRC out), instanced twice (TX, RX).

Verification
REQ-037 CMD0, arg 0, type 00 -> line carries 0x400000000095, oe high 48 strobes, complete pulse, errors 0.
REQ-038 CMD8, arg 0x000001AA, type 01, card replies 0x08000001AA13 after 5 bits -> TX frame 0x48000001AA87, resp_index 8, status 0x000001AA, errors 0.
REQ-039 CMD17, type 01, line held 1 -> complete after 64 strobes of WAIT_RESP, error_flags 4'b1000.
REQ-040 CMD2, type 11, 136-bit reply with payload 0x..FF -> response_status equals payload, only end_bit checked.
REQ-041 Card reply with flipped CRC bit and index 9 for CMD8 -> error_flags 4'b0101.
REQ-042 cmd_abort at TX bit 20, then new_cmd during busy and reset mid-RX -> IDLE, oe 0, no complete, busy-time new_cmd ignored.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the SD CMD line controller:
// FSM encoding, response codes, CRC7 polynomial and frame lengths.
package cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        WAIT_RESP,
        RX,
        CHECK,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_48   = 2'b01,
        RESP_R3   = 2'b10,
        RESP_136  = 2'b11
    } resp_t;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int CMD_LEN  = 48;
    localparam int LONG_LEN = 136;
    localparam int CRC_SPAN = 40;
    localparam int CNT_W    = 16;

endpackage

// File: rtl/cmd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), zero seed, one bit per enable.
module cmd_crc7
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/cmd_line_ctrl.sv
// SD CMD line controller: sends a 48-bit command frame and
// receives/validates the optional 48- or 136-bit response.
module cmd_line_ctrl
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_BITS = 64,
    parameter int NRC_BITS     = 8,
    parameter bit LONG_RESP_EN = 1'b1
) (
    input  logic         CLK_host,
    input  logic         reset,
    input  logic         sd_bit_en,
    input  logic         new_cmd,
    input  logic         cmd_abort,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         cmd_from_sd,
    output logic         cmd_to_sd,
    output logic         cmd_to_sd_oe,
    output logic         cmd_busy,
    output logic         cmd_complete,
    output logic [5:0]   resp_index,
    output logic [127:0] response_status,
    output logic [3:0]   error_flags
);

    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] CRC_POS0 = CNT_W'(CMD_LEN - 2);
    localparam logic [CNT_W-1:0] CRC_END  = CNT_W'(CRC_SPAN);
    localparam logic [CNT_W-1:0] RX_CRC   = CNT_W'(CRC_SPAN - 1);
    localparam logic [CNT_W-1:0] RX_SHORT = CNT_W'(CMD_LEN - 2);
    localparam logic [CNT_W-1:0] RX_LONG  = CNT_W'(LONG_LEN - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(NRC_BITS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    resp_t              rtype_q;
    logic [5:0]         idx_q;
    logic [39:0]        tx_sr;
    logic [127:0]       rx_sr;
    logic               timeout_q;
    logic               line_q;
    logic               oe_q;
    logic               complete_q;
    logic [6:0]         crc_tx;
    logic [6:0]         crc_rx;
    logic [2:0]         crc_pos;
    logic               tx_bit;
    logic [3:0]         chk_flags;
    logic               accept;
    logic               abort;
    logic               long_rx;
    logic               tx_done;
    logic               start_bit;
    logic [CNT_W-1:0]   rx_last;

    assign accept    = (state_q == IDLE) && new_cmd;
    assign abort     = cmd_abort && (state_q != IDLE);
    assign long_rx   = (rtype_q == RESP_136);
    assign rx_last   = long_rx ? RX_LONG : RX_SHORT;
    assign tx_done   = sd_bit_en && (state_q == TX) && (cnt_q == TX_LAST);
    assign start_bit = sd_bit_en && (state_q == WAIT_RESP) && !cmd_from_sd;
    assign crc_pos   = 3'(CRC_POS0 - cnt_q);

    assign cmd_busy     = (state_q != IDLE);
    assign cmd_complete = complete_q;
    assign cmd_to_sd_oe = oe_q;
    assign cmd_to_sd    = oe_q ? line_q : 1'b1;

    cmd_crc7 u_crc_tx (
        .clk   (CLK_host),
        .rst_n (reset),
        .clr   (accept),
        .en    (sd_bit_en && (state_q == TX) && (cnt_q < CRC_END)),
        .din   (tx_sr[39]),
        .crc   (crc_tx)
    );

    // The start bit is taken in WAIT_RESP, so RX feeds only 39 more bits.
    cmd_crc7 u_crc_rx (
        .clk   (CLK_host),
        .rst_n (reset),
        .clr   (accept),
        .en    (start_bit || (sd_bit_en && (state_q == RX) && (cnt_q < RX_CRC))),
        .din   (cmd_from_sd),
        .crc   (crc_rx)
    );

    always_comb begin
        tx_bit = 1'b1;
        if (cnt_q < CRC_END) begin
            tx_bit = tx_sr[39];
        end else if (cnt_q < TX_LAST) begin
            tx_bit = crc_tx[crc_pos];
        end
    end

    always_comb begin
        chk_flags = 4'b0000;
        if (timeout_q) begin
            chk_flags[3] = 1'b1;
        end else begin
            chk_flags[1] = ~rx_sr[0];
            if (rtype_q == RESP_48) begin
                chk_flags[2] = (crc_rx != rx_sr[7:1]);
                chk_flags[0] = (rx_sr[45:40] != idx_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (new_cmd) state_d = TX;
            end
            TX: begin
                if (tx_done) begin
                    state_d = (rtype_q == RESP_NONE) ? GAP : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (start_bit) begin
                    state_d = RX;
                end else if (sd_bit_en && cnt_q == TO_LAST) begin
                    state_d = CHECK;
                end
            end
            RX: begin
                if (sd_bit_en && cnt_q == rx_last) state_d = CHECK;
            end
            CHECK: begin
                state_d = GAP;
            end
            GAP: begin
                if (sd_bit_en && cnt_q == GAP_LAST) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (sd_bit_en && state_q != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_host or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK_host or negedge reset) begin
        if (!reset) begin
            rtype_q         <= RESP_NONE;
            idx_q           <= '0;
            tx_sr           <= '0;
            rx_sr           <= '0;
            timeout_q       <= 1'b0;
            line_q          <= 1'b1;
            oe_q            <= 1'b0;
            complete_q      <= 1'b0;
            resp_index      <= '0;
            response_status <= '0;
            error_flags     <= '0;
        end else begin
            complete_q <= 1'b0;
            if (accept) begin
                rtype_q <= (!LONG_RESP_EN && resp_type == RESP_136)
                         ? RESP_48 : resp_t'(resp_type);
                idx_q       <= cmd_index;
                tx_sr       <= {2'b01, cmd_index, cmd_arg};
                rx_sr       <= '0;
                timeout_q   <= 1'b0;
                error_flags <= '0;
            end
            // Line outputs only move on bit strobes.
            if (sd_bit_en) begin
                oe_q   <= (state_q == TX);
                line_q <= (state_q == TX) ? tx_bit : 1'b1;
            end
            if (sd_bit_en && state_q == TX) begin
                tx_sr <= {tx_sr[38:0], 1'b0};
            end
            if (start_bit || (sd_bit_en && state_q == RX)) begin
                rx_sr <= {rx_sr[126:0], cmd_from_sd};
            end
            if (sd_bit_en && state_q == WAIT_RESP && cmd_from_sd
                && cnt_q == TO_LAST) begin
                timeout_q <= 1'b1;
            end
            if (tx_done && rtype_q == RESP_NONE) begin
                complete_q <= 1'b1;
            end
            if (state_q == CHECK) begin
                complete_q  <= 1'b1;
                error_flags <= chk_flags;
                if (!timeout_q) begin
                    if (long_rx) begin
                        response_status <= rx_sr;
                        resp_index      <= '0;
                    end else begin
                        response_status <= {96'b0, rx_sr[39:8]};
                        resp_index      <= rx_sr[45:40];
                    end
                end
            end
            if (abort) begin
                oe_q       <= 1'b0;
                line_q     <= 1'b1;
                complete_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmd_line_ctrl.sv
// Directed bench for cmd_line_ctrl with a card model driving CMD
// and a scoreboard of expected completions.
module tb_cmd_line_ctrl;

    logic         CLK_host = 1'b0;
    logic         reset = 1'b1;
    logic         sd_bit_en = 1'b0;
    logic         new_cmd = 1'b0;
    logic         cmd_abort = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         cmd_from_sd = 1'b1;
    logic         cmd_to_sd;
    logic         cmd_to_sd_oe;
    logic         cmd_busy;
    logic         cmd_complete;
    logic [5:0]   resp_index;
    logic [127:0] response_status;
    logic [3:0]   error_flags;

    typedef struct {
        logic [47:0]  frame;
        logic [3:0]   flags;
        logic [5:0]   idx;
        bit           chk_idx;
        logic [127:0] status;
        bit           chk_stat;
        int           strobes;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          oe_cnt = 0;
    int          strobe_cnt = 0;
    int          compl_total = 0;
    int          compl_exp = 0;
    logic [47:0] tx_frame = '0;
    bit          stall = 1'b0;

    cmd_line_ctrl dut (
        .CLK_host        (CLK_host),
        .reset           (reset),
        .sd_bit_en       (sd_bit_en),
        .new_cmd         (new_cmd),
        .cmd_abort       (cmd_abort),
        .cmd_index       (cmd_index),
        .cmd_arg         (cmd_arg),
        .resp_type       (resp_type),
        .cmd_from_sd     (cmd_from_sd),
        .cmd_to_sd       (cmd_to_sd),
        .cmd_to_sd_oe    (cmd_to_sd_oe),
        .cmd_busy        (cmd_busy),
        .cmd_complete    (cmd_complete),
        .resp_index      (resp_index),
        .response_status (response_status),
        .error_flags     (error_flags)
    );

    initial forever #5 CLK_host = ~CLK_host;

    // One strobe every fourth clock, suppressible to test stalls.
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge CLK_host);
            #2;
            div = (div + 1) % 4;
            sd_bit_en = (div == 0) && !stall;
        end
    end

    // Line monitor: captures driven bits and counts busy strobes.
    initial forever begin
        @(negedge CLK_host);
        if (sd_bit_en && cmd_to_sd_oe) begin
            tx_frame = {tx_frame[46:0], cmd_to_sd};
            oe_cnt++;
        end
        if (sd_bit_en && cmd_busy) strobe_cnt++;
        if (cmd_complete) compl_total++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge CLK_host);
        #1;
    endtask

    task automatic wait_strobe();
        do @(posedge CLK_host); while (!sd_bit_en);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int k = 39; k >= 0; k--) begin
            fb = d[k] ^ c[6];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] txf(input logic [5:0] i,
                                        input logic [31:0] a);
        logic [39:0] b;
        b = {2'b01, i, a};
        return {b, crc7(b), 1'b1};
    endfunction

    task automatic push(input logic [47:0] f, input logic [3:0] fl,
                        input logic [5:0] i, input bit ci,
                        input logic [127:0] st, input bit cs,
                        input int s);
        exp_t e;
        e.frame = f;
        e.flags = fl;
        e.idx = i;
        e.chk_idx = ci;
        e.status = st;
        e.chk_stat = cs;
        e.strobes = s;
        sb.push_back(e);
        compl_exp++;
    endtask

    task automatic issue(input logic [5:0] i, input logic [31:0] a,
                         input logic [1:0] t, input bit ab);
        cmd_index = i;
        cmd_arg = a;
        resp_type = t;
        new_cmd = 1'b1;
        cmd_abort = ab;
        oe_cnt = 0;
        strobe_cnt = 0;
        tx_frame = '0;
        tick();
        new_cmd = 1'b0;
        cmd_abort = 1'b0;
    endtask

    // Card model: waits for the command to end, idles, then replies.
    task automatic card(input logic [135:0] f, input int len,
                        input int delay, input int nbits);
        int n;
        n = 0;
        while (!cmd_to_sd_oe && n < 2000) begin tick(); n++; end
        while (cmd_to_sd_oe && n < 4000) begin tick(); n++; end
        repeat (delay) wait_strobe();
        for (int i = len - 1; i >= len - nbits; i--) begin
            wait_strobe();
            #1 cmd_from_sd = f[i];
        end
        if (nbits == len) begin
            wait_strobe();
            #1 cmd_from_sd = 1'b1;
        end
    endtask

    task automatic finish_cmd(input string tag);
        exp_t e;
        int   n;
        int   s0;
        n = 0;
        while (!cmd_complete && n < 3000) begin tick(); n++; end
        chk({tag, "_complete"}, cmd_complete, 1);
        if (cmd_complete && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_flags"}, error_flags, e.flags);
            if (e.chk_idx) chk({tag, "_index"}, resp_index, e.idx);
            if (e.chk_stat) chk({tag, "_status"}, response_status, e.status);
            if (e.strobes >= 0) chk({tag, "_latency"}, strobe_cnt, e.strobes);
            s0 = strobe_cnt;
            tick();
            chk({tag, "_pulse"}, cmd_complete, 0);
            n = 0;
            while (cmd_busy && n < 3000) begin tick(); n++; end
            chk({tag, "_idle"}, cmd_busy, 0);
            chk({tag, "_gap"}, strobe_cnt - s0, 8);
            chk({tag, "_frame"}, tx_frame, e.frame);
            chk({tag, "_oe_bits"}, oe_cnt, 48);
        end
    endtask

    initial begin
        logic [127:0] payload;
        logic [39:0]  base;
        logic [47:0]  bad;

        #3 reset = 1'b0;
        repeat (3) tick();
        chk("rst_oe", cmd_to_sd_oe, 0);
        chk("rst_line", cmd_to_sd, 1);
        chk("rst_busy", cmd_busy, 0);
        chk("rst_complete", cmd_complete, 0);
        chk("rst_flags", error_flags, 0);
        chk("rst_index", resp_index, 0);
        chk("rst_status", response_status, 0);
        reset = 1'b1;
        tick();

        // CMD0, no response
        push(48'h400000000095, 4'b0000, '0, 0, '0, 0, 48);
        issue(6'd0, 32'h0, 2'b00, 0);
        chk("cmd0_busy", cmd_busy, 1);
        finish_cmd("cmd0");

        // CMD8 with a clean R7 reply
        push(48'h48000001AA87, 4'b0000, 6'd8, 1, 128'h1AA, 1, -1);
        issue(6'd8, 32'h000001AA, 2'b01, 0);
        card(136'(48'h08000001AA13), 48, 5, 48);
        finish_cmd("cmd8");

        // CMD17, card silent
        push(txf(6'd17, 32'h0), 4'b1000, '0, 0, '0, 0, 112);
        issue(6'd17, 32'h0, 2'b01, 0);
        finish_cmd("cmd17_to");

        // CMD2, 136-bit reply
        payload = 128'h0123456789ABCDEF_FEDCBA98765432FF;
        push(txf(6'd2, 32'h0), 4'b0000, '0, 0, payload, 1, -1);
        issue(6'd2, 32'h0, 2'b11, 0);
        card({8'h3F, payload}, 136, 3, 136);
        finish_cmd("cmd2");

        // CMD8 answered with index 9 and a corrupted CRC
        base = {2'b00, 6'd9, 32'h000001AA};
        bad = {base, crc7(base) ^ 7'h01, 1'b1};
        push(48'h48000001AA87, 4'b0101, 6'd9, 1, 128'h1AA, 1, -1);
        issue(6'd8, 32'h000001AA, 2'b01, 0);
        card(136'(bad), 48, 2, 48);
        finish_cmd("cmd8_bad");

        // R3 reply with a zero end bit: only end_bit is judged
        push(txf(6'd41, 32'h40FF8000), 4'b0010, 6'h3F, 1,
             128'h80FF8000, 1, -1);
        issue(6'd41, 32'h40FF8000, 2'b10, 0);
        card(136'({2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b0}), 48, 1, 48);
        finish_cmd("r3_end");

        // Abort at TX bit 20
        issue(6'd17, 32'h1234, 2'b01, 0);
        for (int n = 0; n < 500 && oe_cnt < 20; n++) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("abort_oe", cmd_to_sd_oe, 0);
        chk("abort_busy", cmd_busy, 0);
        chk("abort_line", cmd_to_sd, 1);
        repeat (500) tick();
        chk("abort_no_complete", compl_total, compl_exp);

        // new_cmd while busy is ignored; strobe stall freezes progress
        push(48'h400000000095, 4'b0000, '0, 0, '0, 0, 48);
        issue(6'd0, 32'h0, 2'b00, 0);
        repeat (5) tick();
        cmd_index = 6'd5;
        resp_type = 2'b01;
        new_cmd = 1'b1;
        tick();
        new_cmd = 1'b0;
        stall = 1'b1;
        repeat (40) tick();
        chk("stall_oe_bits", oe_cnt, 1);
        stall = 1'b0;
        finish_cmd("busy_ign");

        // Abort together with new_cmd in IDLE: command starts
        push(48'h400000000095, 4'b0000, '0, 0, '0, 0, 48);
        issue(6'd0, 32'h0, 2'b00, 1);
        chk("abort_new_busy", cmd_busy, 1);
        finish_cmd("abort_new");

        // Reset in the middle of a response
        issue(6'd8, 32'h000001AA, 2'b01, 0);
        card(136'(48'h08000001AA13), 48, 2, 20);
        reset = 1'b0;
        #1;
        chk("midrx_oe", cmd_to_sd_oe, 0);
        chk("midrx_busy", cmd_busy, 0);
        chk("midrx_complete", cmd_complete, 0);
        chk("midrx_flags", error_flags, 0);
        chk("midrx_status", response_status, 0);
        chk("midrx_index", resp_index, 0);
        cmd_from_sd = 1'b1;
        tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("midrx_idle", cmd_busy, 0);

        chk("total_completes", compl_total, compl_exp);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
